jtag_tap_ctrl: RTL
==================

// Module: jtag_tap_ctrl
// PURPOSE
// - IEEE 1149.1 TAP controller. Sits directly downstream of the JTAG VPI driver in the OR1K WB debug bench.
// - Consumes tms/tdi on tck and drives tdo. Decodes the IR to select IDCODE, BYPASS or the debug-unit chain.
// - Gives the debug unit its Capture/Shift/Update strobes and a select.
// PARAMETERS
// - IR_LEN        4              instruction register width (>=2)
// - IDCODE_VALUE  32'h149511C3   value captured by IDCODE; bit0 must be 1
// - IDCODE_INST   4'b0010        IDCODE opcode; also the reset instruction
// - DEBUG_INST    4'b1000        opcode selecting the external debug chain
// - BYPASS_INST   4'b1111        BYPASS opcode; every undefined opcode also selects BYPASS
// PORTS
// - tck_i           in   1  JTAG clock; the only clock
// - trst_ni         in   1  TAP reset, asynchronous, active-low
// - tms_i           in   1  test mode select, sampled on rising tck_i
// - tdi_i           in   1  test data in, sampled on rising tck_i
// - tdo_o           out  1  test data out, updated on falling tck_i
// - tdo_oe_o        out  1  tdo enable; high only while shifting
// - debug_tdo_i     in   1  serial out of the debug chain
// - debug_select_o  out  1  latched IR == DEBUG_INST
// - capture_dr_o    out  1  FSM in Capture-DR
// - shift_dr_o      out  1  FSM in Shift-DR
// - pause_dr_o      out  1  FSM in Pause-DR
// - update_dr_o     out  1  FSM in Update-DR
// - tlr_o           out  1  FSM in Test-Logic-Reset
// BEHAVIOUR
// - Reset (trst_ni=0, async)
//   - state=TLR; latched IR=IDCODE_INST; IR shift reg=0; DR shift regs=0.
//   - tdo_o=0; tdo_oe_o=0; all strobes 0 except tlr_o=1.
// - FSM: the 16 standard states, advanced on rising tck_i by tms_i.
//   - TLR: 1->TLR, 0->RTI
//   - RTI: 1->SelDR, 0->RTI
//   - SelDR: 1->SelIR, 0->CapDR
//   - SelIR: 1->TLR, 0->CapIR
//   - Cap*: 1->Exit1, 0->Shift
//   - Shift: 1->Exit1, 0->Shift
//   - Exit1: 1->Update, 0->Pause
//   - Pause: 1->Exit2, 0->Pause
//   - Exit2: 1->Update, 0->Shift
//   - Update: 1->SelDR, 0->RTI
// - Five rising edges with tms=1 reach TLR from any state.
// - While in TLR, latched IR is forced to IDCODE_INST every cycle.
// - IR path
//   - Capture-IR loads {0..0,2'b01}.
//   - Shift-IR shifts LSB-first: tdi_i enters MSB, LSB goes to tdo.
//   - Latched IR takes the shift reg on the rising edge that leaves Update-IR.
//   - Passing through Update-IR without a shift re-latches the unchanged capture value.
// - DR path, muxed by latched IR
//   - IDCODE: Capture-DR loads IDCODE_VALUE; 32-bit LSB-first shift.
//   - BYPASS/undefined: 1-bit reg; Capture-DR loads 0; one tck of delay.
//   - DEBUG: no local DR. tdo source is debug_tdo_i; the debug unit shifts on shift_dr_o.
// - Output timing
//   - Strobes are combinational decodes of the registered state; zero latency.
//   - tdo_o/tdo_oe_o register on falling tck_i from the current state and mux.
//   - Outside Shift-IR/Shift-DR: tdo_oe_o=0 and tdo_o holds its last value.
// - Pause states hold every shift reg unchanged; Exit2->Shift resumes without re-capture.
// - trst_ni asserted mid-shift: immediate TLR, shift contents discarded, latched IR=IDCODE_INST.
// - Capture and update never coincide with a shift; a reg changes at most once per rising edge.
// STRUCTURE
// - Package jtag_pkg: tap_state_t enum (16 states, 4-bit); opcode defaults; IR capture constant.
// - Sub-module jtag_tap_fsm: state reg, next-state logic, strobe decode.
// - Top holds IR/DR regs, the tdo mux and the negedge output regs.
// TESTING
// - Drive TMS=1 x5, then TMS=0 x1 -> tlr_o high after 5 edges; state RTI after edge 6.
// - From RTI, TMS 1,0,0 then 32 Shift-DR clocks -> tdo stream LSB-first = 32'h149511C3, tdo_oe_o=1 throughout.
// - Shift-IR with tdi=4'b1111 -> first 4 tdo bits = 1,0,0,0; after Update-IR, a 9-bit DR scan of tdi=0x1A5 returns 0x1A5<<1 (bypass delay).
// - Load DEBUG_INST -> debug_select_o=1; Capture/Shift/Pause/Update-DR each pulse their strobe; tdo_o follows debug_tdo_i one falling edge later.
// - Pause-DR mid-IDCODE (16 bits out), then Exit2->Shift -> remaining 16 bits = 16'h1495.
// - trst_ni low during Shift-DR -> tlr_o=1 and tdo_oe_o=0 immediately; next IDCODE read = 32'h149511C3.

Source files
------------

// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, default opcodes and the IR capture pattern
package jtag_pkg;
  typedef enum logic [3:0] {
    EXIT2_DR   = 4'h0, EXIT1_DR  = 4'h1, SHIFT_DR   = 4'h2, PAUSE_DR = 4'h3,
    SEL_IR     = 4'h4, UPDATE_DR = 4'h5, CAPTURE_DR = 4'h6, SEL_DR   = 4'h7,
    EXIT2_IR   = 4'h8, EXIT1_IR  = 4'h9, SHIFT_IR   = 4'hA, PAUSE_IR = 4'hB,
    RTI        = 4'hC, UPDATE_IR = 4'hD, CAPTURE_IR = 4'hE, TLR      = 4'hF
  } tap_state_t;
  localparam int          IR_LEN_DEF       = 4;
  localparam logic [31:0] IDCODE_VALUE_DEF = 32'h149511C3;
  localparam logic [3:0]  IDCODE_INST_DEF  = 4'b0010;
  localparam logic [3:0]  DEBUG_INST_DEF   = 4'b1000;
  localparam logic [3:0]  BYPASS_INST_DEF  = 4'b1111;
  localparam logic [1:0]  IR_CAPTURE_LSBS  = 2'b01;
endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// jtag_tap_ctrl_if: TAP pins plus the debug-unit strobe/select bundle
interface jtag_tap_ctrl_if;
  logic tms_i, tdi_i, tdo_o, tdo_oe_o, debug_tdo_i;
  logic debug_select_o, capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o, tlr_o;
  modport slave (
    input  tms_i, tdi_i, debug_tdo_i,
    output tdo_o, tdo_oe_o, debug_select_o, capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o, tlr_o
  );
  modport master (
    output tms_i, tdi_i, debug_tdo_i,
    input  tdo_o, tdo_oe_o, debug_select_o, capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o, tlr_o
  );
endinterface

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: TAP state register, tms-driven transitions and DR strobe decode
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck_i,
  input  logic       trst_ni,
  input  logic       tms_i,
  output tap_state_t state,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       pause_dr,
  output logic       update_dr,
  output logic       tlr
);
  tap_state_t state_nxt;
  // next state from the standard 16-state transition graph
  always_comb begin
    state_nxt = TLR;
    case (state)
      TLR:                      state_nxt = tms_i ? TLR : RTI;
      RTI, UPDATE_DR, UPDATE_IR: state_nxt = tms_i ? SEL_DR : RTI;
      SEL_DR:                   state_nxt = tms_i ? SEL_IR : CAPTURE_DR;
      SEL_IR:                   state_nxt = tms_i ? TLR : CAPTURE_IR;
      CAPTURE_DR, SHIFT_DR:     state_nxt = tms_i ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR:                 state_nxt = tms_i ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:                 state_nxt = tms_i ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR:                 state_nxt = tms_i ? UPDATE_DR : SHIFT_DR;
      CAPTURE_IR, SHIFT_IR:     state_nxt = tms_i ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR:                 state_nxt = tms_i ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:                 state_nxt = tms_i ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR:                 state_nxt = tms_i ? UPDATE_IR : SHIFT_IR;
    endcase
  end
  // state register, TLR on TAP reset
  always_ff @(posedge tck_i or negedge trst_ni)
    if (!trst_ni) state <= TLR;
    else state <= state_nxt;
  assign capture_dr = state == CAPTURE_DR;
  assign shift_dr   = state == SHIFT_DR;
  assign pause_dr   = state == PAUSE_DR;
  assign update_dr  = state == UPDATE_DR;
  assign tlr        = state == TLR;
endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP with IDCODE, BYPASS and an external debug chain
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int                IR_LEN       = IR_LEN_DEF,
  parameter logic [31:0]       IDCODE_VALUE = IDCODE_VALUE_DEF,
  parameter logic [IR_LEN-1:0] IDCODE_INST  = IR_LEN'(IDCODE_INST_DEF),
  parameter logic [IR_LEN-1:0] DEBUG_INST   = IR_LEN'(DEBUG_INST_DEF),
  parameter logic [IR_LEN-1:0] BYPASS_INST  = IR_LEN'(BYPASS_INST_DEF)
)(
  input logic             tck_i,
  input logic             trst_ni,
  jtag_tap_ctrl_if.slave  bus
);
  localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(IR_CAPTURE_LSBS);
  tap_state_t state;
  logic [IR_LEN-1:0] ir_sr, ir;
  logic [31:0] idcode_sr;
  logic bypass_sr, sel_idcode, sel_debug, sel_bypass, shifting, tdo_mux;
  jtag_tap_fsm u_fsm (
    .tck_i,
    .trst_ni,
    .tms_i      (bus.tms_i),
    .state,
    .capture_dr (bus.capture_dr_o),
    .shift_dr   (bus.shift_dr_o),
    .pause_dr   (bus.pause_dr_o),
    .update_dr  (bus.update_dr_o),
    .tlr        (bus.tlr_o)
  );
  assign sel_idcode         = ir == IDCODE_INST;
  assign sel_debug          = ir == DEBUG_INST;
  assign sel_bypass         = ir == BYPASS_INST || !(sel_idcode || sel_debug);
  assign bus.debug_select_o = sel_debug;
  assign shifting           = state == SHIFT_IR || state == SHIFT_DR;
  assign tdo_mux            = state == SHIFT_IR ? ir_sr[0] :
                              sel_idcode ? idcode_sr[0] :
                              sel_debug ? bus.debug_tdo_i : bypass_sr;
  // IR shift register and latched instruction; TLR keeps reloading IDCODE
  always_ff @(posedge tck_i or negedge trst_ni)
    if (!trst_ni) begin
      ir_sr <= '0;
      ir    <= IDCODE_INST;
    end else begin
      ir_sr <= state == CAPTURE_IR ? IR_CAPTURE :
               state == SHIFT_IR ? {bus.tdi_i, ir_sr[IR_LEN-1:1]} : ir_sr;
      ir    <= state == TLR ? IDCODE_INST : state == UPDATE_IR ? ir_sr : ir;
    end
  // local data registers; only the one selected by the IR moves
  always_ff @(posedge tck_i or negedge trst_ni)
    if (!trst_ni) begin
      idcode_sr <= '0;
      bypass_sr <= 1'b0;
    end else begin
      idcode_sr <= !sel_idcode ? idcode_sr : state == CAPTURE_DR ? IDCODE_VALUE :
                   state == SHIFT_DR ? {bus.tdi_i, idcode_sr[31:1]} : idcode_sr;
      bypass_sr <= !sel_bypass ? bypass_sr : state == CAPTURE_DR ? 1'b0 :
                   state == SHIFT_DR ? bus.tdi_i : bypass_sr;
    end
  // tdo launched on the falling edge; held outside the shift states
  always_ff @(negedge tck_i or negedge trst_ni)
    if (!trst_ni) begin
      bus.tdo_o    <= 1'b0;
      bus.tdo_oe_o <= 1'b0;
    end else begin
      bus.tdo_oe_o <= shifting;
      bus.tdo_o    <= shifting ? tdo_mux : bus.tdo_o;
    end
endmodule
